// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: HD44780 LCD controller with power-up init sequence and valid/ready write port
module lcd_hd44780_ctrl #(
    parameter int BUS_W     = 8,
    parameter int LINES     = 2,
    parameter int CURSOR    = 1,
    parameter int BLINK     = 0,
    parameter int PWRUP_CYC = 750_000,
    parameter int TAS_CYC   = 2,
    parameter int EN_CYC    = 25,
    parameter int CMD_CYC   = 2_500,
    parameter int LONG_CYC  = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);
    localparam int MAXC = PWRUP_CYC > LONG_CYC ? PWRUP_CYC : LONG_CYC;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PWR_END = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] TAS_END = CW'(TAS_CYC - 1);
    localparam logic [CW-1:0] EN_END = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] CMD_END = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] LONG_END = CW'(LONG_CYC - 1);
    localparam logic [2:0] LAST_IDX = BUS_W == 4 ? 3'd7 : 3'd3;
    localparam logic [7:0] FSET = (LINES == 2 ? 8'h38 : 8'h30) & (BUS_W == 4 ? 8'hEF : 8'hFF);
    localparam logic [7:0] DISP = 8'h0C | (CURSOR != 0 ? 8'h02 : 8'h00) | (BLINK != 0 ? 8'h01 : 8'h00);

    typedef enum logic [2:0] {POWERUP, INIT_LOAD, SETUP, PULSE, WAIT, IDLE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    byte_q;
    logic          rs_q;
    logic          lo_q;
    logic          single_q;
    logic          init_q;
    logic          ready_q;
    logic          done_q;
    logic          en_q;
    logic          lcd_rs_q;
    logic [7:0]    lcd_data_q;
    logic          wake;
    logic          last;
    logic          long_wait;
    logic [7:0]    init_b;
    logic [7:0]    src_b;
    logic [CW-1:0] wait_end;

    // init word lookup, byte source and post-pulse wait length for the current nibble
    always_comb begin
        wake = BUS_W == 4 && !idx_q[2];
        init_b = wake ? (idx_q[1:0] == 2'd3 ? 8'h20 : 8'h30) :
                 idx_q[1:0] == 2'd0 ? FSET :
                 idx_q[1:0] == 2'd1 ? DISP :
                 idx_q[1:0] == 2'd2 ? 8'h01 : 8'h06;
        src_b = init_q ? init_b : byte_q;
        last = BUS_W == 8 || lo_q || single_q;
        long_wait = single_q || (last && !rs_q && byte_q[7:2] == 6'd0);
        wait_end = long_wait ? LONG_END : CMD_END;
    end

    // sequencer: power-up delay, init list, then one accepted write at a time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= POWERUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            byte_q     <= '0;
            rs_q       <= 1'b0;
            lo_q       <= 1'b0;
            single_q   <= 1'b0;
            init_q     <= 1'b1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            en_q       <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= '0;
        end else begin
            case (state_q)
                POWERUP: begin
                    cnt_q <= cnt_q == PWR_END ? '0 : cnt_q + 1'b1;
                    if (cnt_q == PWR_END) state_q <= INIT_LOAD;
                end
                INIT_LOAD: begin
                    byte_q     <= src_b;
                    rs_q       <= !init_q && rs_q;
                    lcd_rs_q   <= !init_q && rs_q;
                    single_q   <= init_q && wake;
                    lo_q       <= 1'b0;
                    lcd_data_q <= BUS_W == 4 ? {src_b[7:4], 4'h0} : src_b;
                    state_q    <= SETUP;
                end
                SETUP: begin
                    cnt_q <= cnt_q == TAS_END ? '0 : cnt_q + 1'b1;
                    if (cnt_q == TAS_END) begin
                        en_q    <= 1'b1;
                        state_q <= PULSE;
                    end
                end
                PULSE: begin
                    cnt_q <= cnt_q == EN_END ? '0 : cnt_q + 1'b1;
                    if (cnt_q == EN_END) begin
                        en_q    <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q == wait_end ? '0 : cnt_q + 1'b1;
                    if (cnt_q == wait_end) begin
                        if (!last) begin
                            lo_q       <= 1'b1;
                            lcd_data_q <= {byte_q[3:0], 4'h0};
                            state_q    <= SETUP;
                        end else if (init_q && idx_q != LAST_IDX) begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= INIT_LOAD;
                        end else begin
                            init_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (wr_valid) begin
                        byte_q  <= wr_data;
                        rs_q    <= wr_rs;
                        ready_q <= 1'b0;
                        state_q <= INIT_LOAD;
                    end
                end
                default: state_q <= POWERUP;
            endcase
        end
    end

    assign wr_ready  = ready_q;
    assign busy      = ~ready_q;
    assign init_done = done_q;
    assign lcd_en    = en_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_data  = lcd_data_q;
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb_lcd_hd44780_ctrl: bench for the HD44780 controller in 8-bit (u8) and 4-bit (u4) bus modes
module tb_lcd_hd44780_ctrl;
    localparam int PWR = 20;
    localparam int TAS = 2;
    localparam int ENC = 4;
    localparam int CMD = 10;
    localparam int LONG = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       chk = 1'b0;
    logic [1:0] wv;
    logic [1:0] wrs;
    logic [7:0] wd [2];
    wire  [1:0] rdy, dn, bsy, en, rs, rw;
    wire  [7:0] dat0, dat1;

    lcd_hd44780_ctrl #(.BUS_W(8), .LINES(2), .CURSOR(1), .BLINK(0), .PWRUP_CYC(PWR), .TAS_CYC(TAS),
                       .EN_CYC(ENC), .CMD_CYC(CMD), .LONG_CYC(LONG)) u8 (
        .clk(clk), .rst(rst), .wr_valid(wv[0]), .wr_ready(rdy[0]), .wr_rs(wrs[0]), .wr_data(wd[0]),
        .init_done(dn[0]), .busy(bsy[0]), .lcd_en(en[0]), .lcd_rs(rs[0]), .lcd_rw(rw[0]), .lcd_data(dat0));

    lcd_hd44780_ctrl #(.BUS_W(4), .LINES(2), .CURSOR(1), .BLINK(0), .PWRUP_CYC(PWR), .TAS_CYC(TAS),
                       .EN_CYC(ENC), .CMD_CYC(CMD), .LONG_CYC(LONG)) u4 (
        .clk(clk), .rst(rst), .wr_valid(wv[1]), .wr_ready(rdy[1]), .wr_rs(wrs[1]), .wr_data(wd[1]),
        .init_done(dn[1]), .busy(bsy[1]), .lcd_en(en[1]), .lcd_rs(rs[1]), .lcd_rw(rw[1]), .lcd_data(dat1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(string nm, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Model: every transfer expands into a queue of per-cycle {en, rs, data} entries
    logic [9:0] mq [2][1024];
    int         hd [2];
    int         tl [2];
    int         acc [2] = '{0, 0};
    logic [9:0] cur [2];
    logic [1:0] rdy_m, done_m;

    task automatic put(int u, int n, logic e, logic r, logic [7:0] d);
        for (int i = 0; i < n; i++) begin
            mq[u][tl[u] % 1024] = {e, r, d};
            tl[u]++;
        end
    endtask

    task automatic xfer(int u, logic r, logic [7:0] b, bit single);
        logic [9:0] prev;
        int dl;
        logic [7:0] hi, lo;
        prev = tl[u] == hd[u] ? cur[u] : mq[u][(tl[u] - 1) % 1024];
        dl = (single || (!r && b < 8'd4)) ? LONG : CMD;
        hi = {b[7:4], 4'h0};
        lo = {b[3:0], 4'h0};
        put(u, 1, 1'b0, prev[8], prev[7:0]);
        if (u == 0) begin
            put(u, TAS, 1'b0, r, b);
            put(u, ENC, 1'b1, r, b);
            put(u, dl, 1'b0, r, b);
        end else begin
            put(u, TAS, 1'b0, r, hi);
            put(u, ENC, 1'b1, r, hi);
            put(u, single ? dl : CMD, 1'b0, r, hi);
            if (!single) begin
                put(u, TAS, 1'b0, r, lo);
                put(u, ENC, 1'b1, r, lo);
                put(u, dl, 1'b0, r, lo);
            end
        end
    endtask

    task automatic boot(int u);
        logic [7:0] lst [4];
        lst = '{8'h38, 8'h0E, 8'h01, 8'h06};
        hd[u] = 0;
        tl[u] = 0;
        cur[u] = '0;
        rdy_m[u] = 1'b0;
        done_m[u] = 1'b0;
        put(u, PWR - 1, 1'b0, 1'b0, 8'h00);
        if (u == 1) begin
            xfer(1, 1'b0, 8'h30, 1'b1);
            xfer(1, 1'b0, 8'h30, 1'b1);
            xfer(1, 1'b0, 8'h30, 1'b1);
            xfer(1, 1'b0, 8'h20, 1'b1);
            lst[0] = 8'h28;
        end
        for (int i = 0; i < 4; i++) xfer(u, 1'b0, lst[i], 1'b0);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            boot(0);
            boot(1);
        end else begin
            for (int u = 0; u < 2; u++) begin
                if (rdy_m[u] && wv[u]) begin
                    xfer(u, wrs[u], wd[u], 1'b0);
                    acc[u]++;
                end
                if (hd[u] != tl[u]) begin
                    cur[u] = mq[u][hd[u] % 1024];
                    hd[u]++;
                    rdy_m[u] = 1'b0;
                end else begin
                    cur[u][9] = 1'b0;
                    rdy_m[u] = 1'b1;
                    done_m[u] = 1'b1;
                end
            end
        end
    end

    // Compare process: all DUT outputs against the model on every cycle
    initial forever begin
        @(negedge clk);
        if (chk) begin
            for (int u = 0; u < 2; u++) begin
                check(u == 0 ? "cycle_u8" : "cycle_u4",
                      {18'h0, en[u], rs[u], u == 0 ? dat0 : dat1, rdy[u], dn[u], bsy[u], rw[u]},
                      {18'h0, cur[u], rdy_m[u], done_m[u], ~rdy_m[u], 1'b0});
            end
        end
    end

    // EN pulse monitor: count pulses and record data/rs and cycle at each rising edge
    logic [95:0] hist [2];
    int          pulses [2] = '{0, 0};
    int          rise_c [2] = '{0, 0};
    logic [1:0]  rs_at = 2'b00;
    logic [1:0]  pen = 2'b00;
    initial forever begin
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            if (en[u] === 1'b1 && !pen[u]) begin
                hist[u] = {hist[u][87:0], u == 0 ? dat0 : dat1};
                pulses[u]++;
                rise_c[u] = cyc;
                rs_at[u] = rs[u];
            end
            pen[u] = en[u] === 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(int u, logic r, logic [7:0] d, output int lat, output int k);
        int n;
        n = 0;
        while (!rdy[u] && n < 3000) begin
            tick();
            n++;
        end
        check("ready_before_send", {31'h0, rdy[u]}, 1);
        wv[u] = 1'b1;
        wrs[u] = r;
        wd[u] = d;
        tick();
        wv[u] = 1'b0;
        k = cyc;
        lat = 0;
        while (!rdy[u] && lat < 3000) begin
            tick();
            lat++;
        end
    endtask

    task automatic boot_wait();
        int t8, t4, p0, p1;
        t8 = -1;
        t4 = -1;
        p0 = pulses[0];
        p1 = pulses[1];
        rst = 1'b0;
        for (int m = 1; m <= 1000 && t4 < 0; m++) begin
            tick();
            if (m == PWR) check("powerup_quiet", pulses[0] - p0 + pulses[1] - p1, 0);
            if (dn[0] && t8 < 0) t8 = m;
            if (dn[1] && t4 < 0) t4 = m;
        end
        check("init8_cycles", t8, 128);
        check("init4_cycles", t4, 420);
        check("init8_pulses", pulses[0] - p0, 4);
        check("init4_pulses", pulses[1] - p1, 12);
        check("init8_bytes", hist[0][31:0], 32'h380E0106);
        check("init4_nibbles_a", hist[1][95:64], 32'h30303020);
        check("init4_nibbles_b", hist[1][63:32], 32'h208000E0);
        check("init4_nibbles_c", hist[1][31:0], 32'h00100060);
    endtask

    logic [8:0] vec [6] = '{9'h141, 9'h002, 9'h014, 9'h003, 9'h004, 9'h101};
    int         want8 [6] = '{17, 57, 17, 57, 17, 17};
    int         lat, k, p, a;

    initial begin
        wv = 2'b00;
        wrs = 2'b00;
        wd[0] = 8'h00;
        wd[1] = 8'h00;
        #1 rst = 1'b1;
        #1 chk = 1'b1;
        tick();
        tick();
        check("reset_outputs", {8'h0, en, rdy, dn, dat0, dat1, rs}, 32'h0);
        boot_wait();
        for (int i = 0; i < 6; i++) begin
            p = pulses[0];
            send(0, vec[i][8], vec[i][7:0], lat, k);
            check("lat8", lat, want8[i]);
            check("rise_offset", rise_c[0] - k, 3);
            check("one_pulse", pulses[0] - p, 1);
            check("byte_at_en", {23'h0, rs_at[0], hist[0][7:0]}, {23'h0, vec[i]});
        end
        p = pulses[0];
        a = acc[0];
        wv[0] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            wd[0] = 8'hA0 + 8'(i);
            wrs[0] = i[0];
            tick();
        end
        wv[0] = 1'b0;
        for (int n = 0; n < 100 && !rdy[0]; n++) tick();
        check("hold_ready", {31'h0, rdy[0]}, 1);
        check("hold_accepts", acc[0] - a, 4);
        check("hold_pulses", pulses[0] - p, acc[0] - a);
        check("hold_last_byte", {24'h0, hist[0][7:0]}, 32'hD6);
        wd[0] = 8'h55;
        wrs[0] = 1'b1;
        wv[0] = 1'b1;
        tick();
        wv[0] = 1'b0;
        for (int n = 0; n < 20 && !en[0]; n++) tick();
        check("en_before_reset", {31'h0, en[0]}, 1);
        #1 rst = 1'b1;
        #1;
        check("reset_mid_pulse", {27'h0, en[0], rdy[0], dn[0], en[1], rdy[1]}, 0);
        tick();
        tick();
        boot_wait();
        p = pulses[1];
        send(1, 1'b1, 8'h4C, lat, k);
        check("lat4", lat, 33);
        check("pulses4", pulses[1] - p, 2);
        check("nibbles4", {16'h0, hist[1][15:0]}, 32'h40C0);
        check("rs4", {31'h0, rs_at[1]}, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
